// File: rtl/lsu_mem_if.sv
// Load/store unit: runs one request/grant/response data-bus access per memory op,
// stalls the pipeline while it is in flight and returns lane-extracted load data.
module lsu_mem_if #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  input  logic        mem_wr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic        stall_out,
  output logic        dbus_req_out,
  output logic        dbus_we_out,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wstrb_out,
  input  logic        dbus_gnt_in,
  input  logic        dbus_rvalid_in,
  input  logic [31:0] dbus_rdata_in,
  input  logic        dbus_err_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic [1:0]         r_size;
  logic               r_uns;
  logic               r_we;
  logic [31:0]        r_load_data;
  logic               r_misal;
  logic               r_err;
  logic               w_complete;
  logic               w_timeout;
  logic               w_tmo_hit;
  logic               w_misal_in;

  function automatic logic [3:0] f_wstrb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [1:0] sz,
                                         input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  assign w_misal_in = f_misaligned(load_size_in, addr_in[1:0]);
  assign w_tmo_hit  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_in) w_next = w_misal_in ? S_DONE : S_REQ;
      end
      S_REQ: begin
        // A completion in the last allowed cycle wins over the timeout.
        if (dbus_gnt_in && dbus_rvalid_in) begin
          w_complete = 1'b1;
          w_next     = S_DONE;
        end else if (w_tmo_hit) begin
          w_timeout  = 1'b1;
          w_next     = S_DONE;
        end else if (dbus_gnt_in) begin
          w_next     = S_RESP;
        end
      end
      S_RESP: begin
        if (dbus_rvalid_in) begin
          w_complete = 1'b1;
          w_next     = S_DONE;
        end else if (w_tmo_hit) begin
          w_timeout  = 1'b1;
          w_next     = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_we        <= 1'b0;
      r_load_data <= '0;
      r_misal     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_REQ || r_state == S_RESP) ? r_cnt + 1'b1 : '0;
      r_misal <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == S_IDLE && req_valid_in) begin
        r_addr  <= addr_in;
        r_wdata <= f_wdata(load_size_in, store_data_in);
        r_wstrb <= mem_wr_in ? f_wstrb(load_size_in, addr_in[1:0]) : 4'b0000;
        r_size  <= load_size_in;
        r_uns   <= load_unsigned_in;
        r_we    <= mem_wr_in;
        if (w_misal_in) begin
          r_misal     <= 1'b1;
          r_load_data <= '0;
        end
      end
      if (w_complete) begin
        r_err       <= dbus_err_in;
        r_load_data <= (dbus_err_in || r_we) ? 32'h0
                       : f_load(dbus_rdata_in, r_size, r_addr[1:0], r_uns);
      end
      if (w_timeout) begin
        r_err       <= 1'b1;
        r_load_data <= '0;
      end
    end
  end

  assign stall_out      = (r_state == S_IDLE) ? req_valid_in
                          : (r_state == S_REQ || r_state == S_RESP);
  assign dbus_req_out   = (r_state == S_REQ);
  assign dbus_we_out    = r_we;
  assign dbus_addr_out  = {r_addr[31:2], 2'b00};
  assign dbus_wdata_out = r_wdata;
  assign dbus_wstrb_out = r_wstrb;
  assign load_data_out  = r_load_data;
  assign load_valid_out = (r_state == S_DONE) && !r_we;
  assign misaligned_out = r_misal;
  assign bus_err_out    = r_err;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed cases plus randomized ops checked against a
// cycle-count/arithmetic model of the access rules.
module tb_lsu_mem_if;
  localparam int TMO = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_valid_in;
  logic        mem_wr_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic        stall_out;
  logic        dbus_req_out;
  logic        dbus_we_out;
  logic [31:0] dbus_addr_out;
  logic [31:0] dbus_wdata_out;
  logic [3:0]  dbus_wstrb_out;
  logic        dbus_gnt_in;
  logic        dbus_rvalid_in;
  logic [31:0] dbus_rdata_in;
  logic        dbus_err_in;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int checks   = 0;
  int failures = 0;

  lsu_mem_if #(.TIMEOUT_CYC(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in),
    .mem_wr_in(mem_wr_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .stall_out(stall_out), .dbus_req_out(dbus_req_out), .dbus_we_out(dbus_we_out),
    .dbus_addr_out(dbus_addr_out), .dbus_wdata_out(dbus_wdata_out),
    .dbus_wstrb_out(dbus_wstrb_out), .dbus_gnt_in(dbus_gnt_in),
    .dbus_rvalid_in(dbus_rvalid_in), .dbus_rdata_in(dbus_rdata_in),
    .dbus_err_in(dbus_err_in), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .misaligned_out(misaligned_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference rules, expressed arithmetically on byte offsets.
  function automatic logic ref_misal(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [1:0] a);
    int s;
    if (sz == 2'd0)      s = 1 << a;
    else if (sz == 2'd1) s = 3 << ((a / 2) * 2);
    else                 s = 15;
    return 4'(s);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (a / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One complete op from IDLE: g = REQ-cycle index of gnt, r = cycles from gnt to rvalid.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] d,
                       input logic [1:0] sz, input logic uns, input int g, input int r,
                       input logic [31:0] rd, input logic err);
    logic [1:0]  a;
    logic        exp_err;
    logic        tmo;
    int          done_k;
    a = addr[1:0];
    req_valid_in = 1'b1; mem_wr_in = we; addr_in = addr; store_data_in = d;
    load_size_in = sz; load_unsigned_in = uns;
    dbus_gnt_in = 1'b0; dbus_rvalid_in = 1'b0; dbus_err_in = 1'b0;
    #1;
    chk("idle_stall", stall_out, 1);
    chk("idle_req", dbus_req_out, 0);
    tick();
    if (ref_misal(sz, a)) begin
      req_valid_in = 1'($urandom_range(0, 1));
      #1;
      chk("mis_pulse", misaligned_out, 1);
      chk("mis_stall", stall_out, 0);
      chk("mis_req", dbus_req_out, 0);
      chk("mis_lvalid", load_valid_out, !we);
      chk("mis_berr", bus_err_out, 0);
      if (!we) chk("mis_ldata", load_data_out, 0);
    end else begin
      tmo     = (g + r) > (TMO - 1);
      done_k  = tmo ? TMO - 1 : g + r;
      exp_err = tmo || err;
      for (int k = 0; k <= done_k; k++) begin
        dbus_gnt_in    = (k == g);
        dbus_rvalid_in = (k == g + r) || (k < g && $urandom_range(0, 3) == 0);
        dbus_err_in    = (k == g + r) ? err : 1'($urandom_range(0, 1));
        dbus_rdata_in  = (k == g + r) ? rd : $urandom;
        #1;
        chk("busy_stall", stall_out, 1);
        chk("busy_req", dbus_req_out, (k <= g));
        chk("busy_lvalid", load_valid_out, 0);
        if (k <= g) begin
          chk("bus_addr", dbus_addr_out, addr & 32'hFFFF_FFFC);
          chk("bus_we", dbus_we_out, we);
          chk("bus_strb", dbus_wstrb_out, we ? ref_strb(sz, a) : 4'b0000);
          if (we) chk("bus_wdata", dbus_wdata_out, ref_wdata(sz, d));
        end
        tick();
      end
      dbus_gnt_in = 1'b0; dbus_rvalid_in = 1'b0; dbus_err_in = 1'b0;
      req_valid_in = 1'($urandom_range(0, 1));
      #1;
      chk("done_stall", stall_out, 0);
      chk("done_req", dbus_req_out, 0);
      chk("done_lvalid", load_valid_out, !we);
      chk("done_berr", bus_err_out, exp_err);
      chk("done_mis", misaligned_out, 0);
      if (!we) chk("done_ldata", load_data_out, exp_err ? 32'h0 : ref_load(rd, sz, a, uns));
    end
    tick();
    req_valid_in = 1'b0;
    #1;
    chk("post_stall", stall_out, 0);
    chk("post_lvalid", load_valid_out, 0);
    chk("post_berr", bus_err_out, 0);
    chk("post_mis", misaligned_out, 0);
    chk("post_req", dbus_req_out, 0);
  endtask

  initial begin
    logic        we, uns, err;
    logic [1:0]  sz;
    logic [31:0] addr, d, rd;
    int          g, r;

    rst_in = 1'b1; req_valid_in = 1'b0; mem_wr_in = 1'b0; addr_in = '0;
    store_data_in = '0; load_size_in = '0; load_unsigned_in = 1'b0;
    dbus_gnt_in = 1'b0; dbus_rvalid_in = 1'b0; dbus_rdata_in = '0; dbus_err_in = 1'b0;
    tick(); tick();
    chk("rst_stall", stall_out, 0);
    chk("rst_req", dbus_req_out, 0);
    chk("rst_we", dbus_we_out, 0);
    chk("rst_strb", dbus_wstrb_out, 0);
    chk("rst_addr", dbus_addr_out, 0);
    chk("rst_ldata", load_data_out, 0);
    chk("rst_lvalid", load_valid_out, 0);
    chk("rst_mis", misaligned_out, 0);
    chk("rst_berr", bus_err_out, 0);
    rst_in = 1'b0;
    tick();

    // Directed cases.
    do_op(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b0, 0, 1, 32'h80FF_1234, 1'b0);
    do_op(1'b0, 32'h0000_2002, 32'h0, 2'd1, 1'b1, 0, 1, 32'h9ABC_0000, 1'b0);
    do_op(1'b1, 32'h0000_3001, 32'h0000_00A5, 2'd0, 1'b0, 0, 1, 32'h0, 1'b0);
    do_op(1'b0, 32'h0000_4002, 32'h0, 2'd2, 1'b0, 0, 1, 32'h0, 1'b0);
    do_op(1'b0, 32'h0000_5004, 32'h0, 2'd2, 1'b0, 1000, 0, 32'h1111_2222, 1'b0);
    do_op(1'b0, 32'h0000_6000, 32'h0, 2'd3, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0);
    do_op(1'b0, 32'h0000_6006, 32'h0, 2'd1, 1'b0, 2, 0, 32'hF00D_0000, 1'b1);
    do_op(1'b0, 32'h0000_7001, 32'h0, 2'd1, 1'b0, 0, 0, 32'h0, 1'b0);
    do_op(1'b1, 32'h0000_7002, 32'h1234_5678, 2'd1, 1'b0, 1, 2, 32'h0, 1'b0);
    do_op(1'b0, 32'h0000_8000, 32'h0, 2'd2, 1'b0, TMO - 1, 0, 32'h0BAD_BEEF, 1'b0);
    do_op(1'b0, 32'h0000_8002, 32'h0, 2'd1, 1'b0, TMO - 2, 1, 32'h8001_0000, 1'b0);
    do_op(1'b0, 32'h0000_8000, 32'h0, 2'd2, 1'b0, TMO - 1, 1, 32'h0BAD_BEEF, 1'b0);

    // Reset while waiting for a response; a late rvalid must then be ignored.
    req_valid_in = 1'b1; mem_wr_in = 1'b0; addr_in = 32'h0000_9000; load_size_in = 2'd2;
    tick();
    dbus_gnt_in = 1'b1;
    tick();
    dbus_gnt_in = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0; req_valid_in = 1'b0;
    #1;
    chk("rstr_stall", stall_out, 0);
    chk("rstr_req", dbus_req_out, 0);
    dbus_rvalid_in = 1'b1; dbus_rdata_in = 32'h5555_AAAA;
    tick();
    dbus_rvalid_in = 1'b0;
    #1;
    chk("rstr_lvalid", load_valid_out, 0);
    chk("rstr_stall2", stall_out, 0);
    chk("rstr_berr", bus_err_out, 0);
    tick();
    chk("rstr_lvalid2", load_valid_out, 0);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      d    = $urandom;
      uns  = 1'($urandom_range(0, 1));
      rd   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz >= 2'd2) addr[1:0] = 2'b00;
      end
      g   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 3));
      r   = $urandom_range(0, 3);
      err = ($urandom_range(0, 7) == 0);
      do_op(we, addr, d, sz, uns, g, r, rd, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
